// File: rtl/vc_dispatch_scheduler.sv
// Per-input-port VC dispatch scheduler: round-robin VC lock, per-packet switch requests,
// and per-output-port downstream credit tracking.
module vc_dispatch_scheduler #(
    parameter int unsigned NUM_VC      = 4,
    parameter int unsigned NUM_PORTS   = 4,
    parameter int unsigned BUF_DEPTH   = 4,
    parameter int unsigned VC_BITS     = $clog2(NUM_VC),
    parameter int unsigned CREDIT_BITS = $clog2(BUF_DEPTH + 1)
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [NUM_VC-1:0]                   vc_valid,
    input  logic [NUM_VC-1:0]                   vc_tail,
    input  logic [NUM_VC-1:0][NUM_PORTS-1:0]    vc_direction,
    input  logic                                sa_grant,
    input  logic [NUM_PORTS-1:0]                credit_return,
    output logic [NUM_PORTS-1:0]                sa_req,
    output logic [NUM_VC-1:0]                   pop,
    output logic [VC_BITS-1:0]                  vc_index,
    output logic                                locked,
    output logic                                credit_err
);

    localparam logic [0:0] StIdle   = 1'b0;
    localparam logic [0:0] StLocked = 1'b1;

    localparam logic [CREDIT_BITS-1:0] CreditMax = CREDIT_BITS'(BUF_DEPTH);
    localparam logic [CREDIT_BITS-1:0] CreditOne = CREDIT_BITS'(1);
    localparam logic [VC_BITS:0]       NumVcW    = (VC_BITS + 1)'(NUM_VC);
    localparam logic [NUM_PORTS-1:0]   PortOne   = NUM_PORTS'(1);
    localparam logic [NUM_VC-1:0]      VcOne     = NUM_VC'(1);

    logic [0:0]                              state_q, state_d;
    logic [VC_BITS-1:0]                      rr_ptr_q, rr_ptr_d;
    logic [VC_BITS-1:0]                      vc_index_q, vc_index_d;
    logic [NUM_PORTS-1:0]                    locked_dir_q, locked_dir_d;
    logic [NUM_PORTS-1:0][CREDIT_BITS-1:0]   credit_q, credit_d;
    logic                                    credit_err_q, credit_err_d;

    logic [NUM_PORTS-1:0] credit_avail;
    logic [NUM_VC-1:0]    vc_elig;
    logic                 pick_found;
    logic [VC_BITS-1:0]   pick_idx;
    logic [VC_BITS:0]     cand;
    logic [VC_BITS:0]     rr_next;
    logic                 req_ok;
    logic                 send;
    logic [NUM_PORTS-1:0] send_port;

    function automatic logic is_onehot(input logic [NUM_PORTS-1:0] v);
        return (v != '0) && ((v & (v - PortOne)) == '0);
    endfunction

    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            credit_avail[p] = (credit_q[p] != '0);
        end
    end

    // A VC is only a candidate if its direction is legal and that port has room downstream.
    always_comb begin
        for (int i = 0; i < NUM_VC; i++) begin
            vc_elig[i] = vc_valid[i] && is_onehot(vc_direction[i])
                         && (|(vc_direction[i] & credit_avail));
        end
    end

    // First eligible VC at or after rr_ptr, wrapping.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = 0; k < NUM_VC; k++) begin
            cand = {1'b0, rr_ptr_q} + (VC_BITS + 1)'(k);
            if (cand >= NumVcW) begin
                cand = cand - NumVcW;
            end
            if (!pick_found && vc_elig[cand[VC_BITS-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = cand[VC_BITS-1:0];
            end
        end
        rr_next = {1'b0, pick_idx} + (VC_BITS + 1)'(1);
        if (rr_next >= NumVcW) begin
            rr_next = '0;
        end
    end

    always_comb begin
        req_ok    = (state_q == StLocked) && vc_valid[vc_index_q]
                    && (|(locked_dir_q & credit_avail));
        sa_req    = req_ok ? locked_dir_q : '0;
        send      = req_ok && sa_grant;
        pop       = send ? (VcOne << vc_index_q) : '0;
        send_port = send ? locked_dir_q : '0;
    end

    // Send and return on the same port cancel; a return at full saturates and flags an error.
    always_comb begin
        credit_d     = credit_q;
        credit_err_d = credit_err_q;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (send_port[p] && !credit_return[p]) begin
                credit_d[p] = credit_q[p] - CreditOne;
            end else if (!send_port[p] && credit_return[p]) begin
                if (credit_q[p] == CreditMax) begin
                    credit_err_d = 1'b1;
                end else begin
                    credit_d[p] = credit_q[p] + CreditOne;
                end
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        vc_index_d   = vc_index_q;
        locked_dir_d = locked_dir_q;
        case (state_q)
            StIdle: begin
                if (pick_found) begin
                    state_d      = StLocked;
                    vc_index_d   = pick_idx;
                    locked_dir_d = vc_direction[pick_idx];
                    rr_ptr_d     = rr_next[VC_BITS-1:0];
                end
            end
            StLocked: begin
                if (send && vc_tail[vc_index_q]) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            rr_ptr_q     <= '0;
            vc_index_q   <= '0;
            locked_dir_q <= '0;
            credit_err_q <= 1'b0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                credit_q[p] <= CreditMax;
            end
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            vc_index_q   <= vc_index_d;
            locked_dir_q <= locked_dir_d;
            credit_err_q <= credit_err_d;
            credit_q     <= credit_d;
        end
    end

    assign vc_index   = vc_index_q;
    assign locked     = (state_q == StLocked);
    assign credit_err = credit_err_q;

endmodule

// File: tb/tb_vc_dispatch_scheduler.sv
// Directed self-checking bench for vc_dispatch_scheduler.
module tb_vc_dispatch_scheduler;

    localparam int NUM_VC    = 4;
    localparam int NUM_PORTS = 4;

    logic                             clk = 1'b0;
    logic                             reset;
    logic [NUM_VC-1:0]                vc_valid;
    logic [NUM_VC-1:0]                vc_tail;
    logic [NUM_VC-1:0][NUM_PORTS-1:0] vc_direction;
    logic                             sa_grant;
    logic [NUM_PORTS-1:0]             credit_return;
    logic [NUM_PORTS-1:0]             sa_req;
    logic [NUM_VC-1:0]                pop;
    logic [1:0]                       vc_index;
    logic                             locked;
    logic                             credit_err;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    vc_dispatch_scheduler dut (
        .clk          (clk),
        .reset        (reset),
        .vc_valid     (vc_valid),
        .vc_tail      (vc_tail),
        .vc_direction (vc_direction),
        .sa_grant     (sa_grant),
        .credit_return(credit_return),
        .sa_req       (sa_req),
        .pop          (pop),
        .vc_index     (vc_index),
        .locked       (locked),
        .credit_err   (credit_err)
    );

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        vc_valid      = '0;
        vc_tail       = '0;
        vc_direction  = '0;
        sa_grant      = 1'b0;
        credit_return = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        next_cycle();
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        next_cycle();
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        total_cnt++;
        if (sa_req !== 4'b0000) $display("FAIL reset_sa_req: got %b expected 0000", sa_req);
        else pass_cnt++;
        total_cnt++;
        if (pop !== 4'b0000) $display("FAIL reset_pop: got %b expected 0000", pop);
        else pass_cnt++;
        total_cnt++;
        if (locked !== 1'b0) $display("FAIL reset_locked: got %b expected 0", locked);
        else pass_cnt++;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        next_cycle();
        @(negedge clk);
        total_cnt++;
        if (locked !== 1'b0) $display("FAIL reset_release_locked: got %b expected 0", locked);
        else pass_cnt++;
        total_cnt++;
        if (credit_err !== 1'b0) $display("FAIL reset_credit_err: got %b expected 0", credit_err);
        else pass_cnt++;
        total_cnt++;
        if (vc_index !== 2'd0) $display("FAIL reset_vc_index: got %0d expected 0", vc_index);
        else pass_cnt++;
    endtask

    task automatic test_single_flit();
        int n;
        do_reset();
        vc_valid        = 4'b0100;
        vc_tail         = 4'b0100;
        vc_direction[2] = 4'b0100;
        sa_grant        = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (locked !== 1'b0) $display("FAIL single_c0_locked: got %b expected 0", locked);
        else pass_cnt++;
        next_cycle();
        @(negedge clk);
        total_cnt++;
        if (locked !== 1'b1) $display("FAIL single_c1_locked: got %b expected 1", locked);
        else pass_cnt++;
        total_cnt++;
        if (vc_index !== 2'd2) $display("FAIL single_vc_index: got %0d expected 2", vc_index);
        else pass_cnt++;
        total_cnt++;
        if (sa_req !== 4'b0100) $display("FAIL single_sa_req: got %b expected 0100", sa_req);
        else pass_cnt++;
        total_cnt++;
        if (pop !== 4'b0100) $display("FAIL single_pop: got %b expected 0100", pop);
        else pass_cnt++;
        next_cycle();
        vc_valid = 4'b0000;
        @(negedge clk);
        total_cnt++;
        if (locked !== 1'b0) $display("FAIL single_c2_idle: got %b expected 0", locked);
        else pass_cnt++;
        // Port 2 should now hold 3 credits: a long packet drains exactly three.
        next_cycle();
        vc_valid = 4'b0100;
        vc_tail  = 4'b0000;
        n = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (pop[2] === 1'b1) n++;
            next_cycle();
        end
        total_cnt++;
        if (n != 3) $display("FAIL single_credit_left: got %0d pops expected 3", n);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (sa_req !== 4'b0000) $display("FAIL single_stall_req: got %b expected 0000", sa_req);
        else pass_cnt++;
    endtask

    task automatic test_credit_exhaustion();
        do_reset();
        vc_valid        = 4'b0001;
        vc_tail         = 4'b0000;
        vc_direction[0] = 4'b0010;
        sa_grant        = 1'b1;
        next_cycle();
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            total_cnt++;
            if (pop !== 4'b0001) $display("FAIL exh_pop%0d: got %b expected 0001", i, pop);
            else pass_cnt++;
            total_cnt++;
            if (sa_req !== 4'b0010) $display("FAIL exh_req%0d: got %b expected 0010", i, sa_req);
            else pass_cnt++;
            next_cycle();
        end
        @(negedge clk);
        total_cnt++;
        if (sa_req !== 4'b0000 || pop !== 4'b0000)
            $display("FAIL exh_stall: got req %b pop %b expected 0000 0000", sa_req, pop);
        else pass_cnt++;
        total_cnt++;
        if (locked !== 1'b1) $display("FAIL exh_still_locked: got %b expected 1", locked);
        else pass_cnt++;
        credit_return = 4'b0010;
        next_cycle();
        credit_return = 4'b0000;
        @(negedge clk);
        total_cnt++;
        if (sa_req !== 4'b0010 || pop !== 4'b0001)
            $display("FAIL exh_pop5: got req %b pop %b expected 0010 0001", sa_req, pop);
        else pass_cnt++;
        next_cycle();
        @(negedge clk);
        total_cnt++;
        if (sa_req !== 4'b0000) $display("FAIL exh_stall2: got %b expected 0000", sa_req);
        else pass_cnt++;
        credit_return = 4'b0010;
        next_cycle();
        credit_return = 4'b0000;
        vc_tail       = 4'b0001;
        @(negedge clk);
        total_cnt++;
        if (pop !== 4'b0001) $display("FAIL exh_pop6: got %b expected 0001", pop);
        else pass_cnt++;
        next_cycle();
        @(negedge clk);
        total_cnt++;
        if (locked !== 1'b0) $display("FAIL exh_tail_idle: got %b expected 0", locked);
        else pass_cnt++;
        total_cnt++;
        if (credit_err !== 1'b0) $display("FAIL exh_no_err: got %b expected 0", credit_err);
        else pass_cnt++;
    endtask

    task automatic test_round_robin();
        int          exp_order [6] = '{0, 3, 0, 1, 3, 0};
        int          n;
        logic [3:0]  exp_pop;
        logic [3:0]  one;
        do_reset();
        vc_valid        = 4'b1001;
        vc_tail         = 4'b1111;
        vc_direction[0] = 4'b0001;
        vc_direction[1] = 4'b0010;
        vc_direction[3] = 4'b1000;
        sa_grant        = 1'b1;
        one             = 4'b0001;
        n               = 0;
        for (int c = 0; c < 24 && n < 6; c++) begin
            @(negedge clk);
            if (locked === 1'b1) begin
                exp_pop = one << exp_order[n];
                total_cnt++;
                if (vc_index !== 2'(exp_order[n]))
                    $display("FAIL rr_lock%0d: got vc %0d expected %0d", n, vc_index,
                             exp_order[n]);
                else pass_cnt++;
                total_cnt++;
                if (pop !== exp_pop)
                    $display("FAIL rr_pop%0d: got %b expected %b", n, pop, exp_pop);
                else pass_cnt++;
                n++;
                if (n == 3) vc_valid = 4'b1011;
            end
            next_cycle();
        end
        total_cnt++;
        if (n != 6) $display("FAIL rr_timeout: got %0d locks expected 6", n);
        else pass_cnt++;
    endtask

    task automatic test_simultaneous();
        int n;
        do_reset();
        vc_valid        = 4'b0001;
        vc_tail         = 4'b0000;
        vc_direction[0] = 4'b0010;
        sa_grant        = 1'b1;
        next_cycle();
        next_cycle();
        next_cycle();
        // Port 1 is at 2 here; send and return together must leave it at 2.
        credit_return = 4'b0010;
        @(negedge clk);
        total_cnt++;
        if (pop !== 4'b0001) $display("FAIL simul_pop: got %b expected 0001", pop);
        else pass_cnt++;
        next_cycle();
        credit_return = 4'b0000;
        n = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (pop[0] === 1'b1) n++;
            next_cycle();
        end
        total_cnt++;
        if (n != 2) $display("FAIL simul_credit: got %0d pops expected 2", n);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (pop !== 4'b0000 || sa_req !== 4'b0000)
            $display("FAIL grant_no_req: got pop %b req %b expected 0000 0000", pop, sa_req);
        else pass_cnt++;
        total_cnt++;
        if (credit_err !== 1'b0) $display("FAIL simul_no_err: got %b expected 0", credit_err);
        else pass_cnt++;

        do_reset();
        credit_return = 4'b0100;
        next_cycle();
        credit_return = 4'b0000;
        @(negedge clk);
        total_cnt++;
        if (credit_err !== 1'b1) $display("FAIL sat_err: got %b expected 1", credit_err);
        else pass_cnt++;
        next_cycle();
        next_cycle();
        next_cycle();
        @(negedge clk);
        total_cnt++;
        if (credit_err !== 1'b1) $display("FAIL sat_sticky: got %b expected 1", credit_err);
        else pass_cnt++;
        next_cycle();
        vc_valid        = 4'b0010;
        vc_tail         = 4'b0000;
        vc_direction[1] = 4'b0100;
        sa_grant        = 1'b1;
        n = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (pop[1] === 1'b1) n++;
            next_cycle();
        end
        total_cnt++;
        if (n != 4) $display("FAIL sat_credit: got %0d pops expected 4", n);
        else pass_cnt++;
    endtask

    task automatic test_mid_reset();
        do_reset();
        vc_valid        = 4'b0010;
        vc_tail         = 4'b0000;
        vc_direction[1] = 4'b0001;
        vc_direction[3] = 4'b0100;
        sa_grant        = 1'b1;
        next_cycle();
        @(negedge clk);
        total_cnt++;
        if (pop !== 4'b0010) $display("FAIL midrst_flit1: got %b expected 0010", pop);
        else pass_cnt++;
        next_cycle();
        @(negedge clk);
        total_cnt++;
        if (pop !== 4'b0010) $display("FAIL midrst_flit2: got %b expected 0010", pop);
        else pass_cnt++;
        #1;
        reset = 1'b0;
        #1;
        total_cnt++;
        if (locked !== 1'b0) $display("FAIL midrst_locked: got %b expected 0", locked);
        else pass_cnt++;
        total_cnt++;
        if (pop !== 4'b0000 || sa_req !== 4'b0000)
            $display("FAIL midrst_outputs: got pop %b req %b expected 0000 0000", pop, sa_req);
        else pass_cnt++;
        total_cnt++;
        if (vc_index !== 2'd0) $display("FAIL midrst_vc_index: got %0d expected 0", vc_index);
        else pass_cnt++;
        vc_valid = 4'b1010;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        next_cycle();
        @(negedge clk);
        total_cnt++;
        if (locked !== 1'b1 || vc_index !== 2'd1)
            $display("FAIL midrst_relock: got locked %b vc %0d expected 1 1", locked, vc_index);
        else pass_cnt++;
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        test_reset();
        test_single_flit();
        test_credit_exhaustion();
        test_round_robin();
        test_simultaneous();
        test_mid_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d of %0d checks passed",
                 pass_cnt, total_cnt);
        $fatal(1);
    end

endmodule
